// File: rtl/elementary_ca_array.sv
// One-dimensional elementary cellular automaton over WIDTH cells; a generation is
// produced on a timer tick or a step request. Byte-wide load and read ports access the cells.
module elementary_ca_array #(
    parameter int          WIDTH        = 32,
    parameter logic [23:0] MAX_COUNT    = 24'd10_000_000,
    parameter logic [7:0]  RULE_DEFAULT = 8'd110
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          step_req,
    input  logic                          wrap_en,
    input  logic [7:0]                    rule_in,
    input  logic                          rule_we,
    input  logic [$clog2(WIDTH/8)-1:0]    load_addr,
    input  logic [7:0]                    load_data,
    input  logic                          load_we,
    input  logic [$clog2(WIDTH/8)-1:0]    rd_addr,
    output logic [7:0]                    rd_data,
    output logic [15:0]                   gen_count,
    output logic                          step_done,
    output logic                          alive,
    output logic                          still
);
    localparam int NB = WIDTH / 8;
    localparam int AW = $clog2(NB);

    logic [WIDTH-1:0] cells;
    logic [WIDTH-1:0] cells_nxt;
    logic [WIDTH+1:0] ext;
    logic [7:0]       rule;
    logic [23:0]      timer;
    logic             tick;
    logic             trigger;
    logic             gen;

    assign tick    = run && (timer == MAX_COUNT - 24'd1);
    assign trigger = tick || step_req;
    // A byte load wins over a generation in the same cycle.
    assign gen     = trigger && !load_we;
    assign alive   = |cells;

    // Cells padded with their edge neighbours: ext[i+1] is cells[i], ext[i+2] its left.
    assign ext = {wrap_en & cells[0], cells, wrap_en & cells[WIDTH-1]};

    always_comb begin
        cells_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cells_nxt[i] = rule[{ext[i+2], ext[i+1], ext[i]}];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (rd_addr == AW'(b)) begin
                rd_data = cells[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cells     <= {{(WIDTH-1){1'b0}}, 1'b1};
            rule      <= RULE_DEFAULT;
            timer     <= '0;
            gen_count <= '0;
            step_done <= 1'b0;
            still     <= 1'b0;
        end else begin
            timer     <= (!run || tick) ? 24'd0 : timer + 24'd1;
            step_done <= gen;
            if (rule_we) begin
                rule <= rule_in;
            end
            if (load_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (load_addr == AW'(b)) begin
                        cells[8*b +: 8] <= load_data;
                    end
                end
                still <= 1'b0;
            end else if (gen) begin
                cells     <= cells_nxt;
                gen_count <= gen_count + 16'd1;
                still     <= (cells_nxt == cells);
            end
        end
    end
endmodule

// File: tb/tb_elementary_ca_array.sv
// Directed bench for elementary_ca_array at WIDTH=16, MAX_COUNT=4, rule 110.
module tb_elementary_ca_array;
    localparam logic [23:0] MC = 24'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic        wrap_en = 1'b0;
    logic [7:0]  rule_in = 8'h00;
    logic        rule_we = 1'b0;
    logic [0:0]  load_addr = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic        load_we = 1'b0;
    logic [0:0]  rd_addr = 1'b0;
    logic [7:0]  rd_data;
    logic [15:0] gen_count;
    logic        step_done;
    logic        alive;
    logic        still;

    int n_checks = 0;
    int n_errors = 0;

    elementary_ca_array #(
        .WIDTH(16),
        .MAX_COUNT(MC),
        .RULE_DEFAULT(8'd110)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .step_req(step_req),
        .wrap_en(wrap_en),
        .rule_in(rule_in),
        .rule_we(rule_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_we(load_we),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .gen_count(gen_count),
        .step_done(step_done),
        .alive(alive),
        .still(still)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_cells(output logic [15:0] v);
        rd_addr = 1'b0;
        #1;
        v[7:0] = rd_data;
        rd_addr = 1'b1;
        #1;
        v[15:8] = rd_data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic step();
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
    endtask

    task automatic load(input logic a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_we   = 1'b1;
        cyc();
        load_we   = 1'b0;
    endtask

    logic [15:0] cv;
    logic [15:0] g0;
    logic [15:0] exp30 [3] = '{16'h0003, 16'h0007, 16'h000D};
    logic [11:0] done_mask;
    logic [3:0]  m4;
    int          nd;

    initial begin
        // Reset state
        do_reset();
        rd_cells(cv);
        chk("rst_cells", cv, 16'h0001);
        chk("rst_gen", gen_count, 16'h0000);
        chk("rst_done", step_done, 1'b0);
        chk("rst_still", still, 1'b0);
        chk("rst_alive", alive, 1'b1);

        // Three single steps, no wrap
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (step_done) nd++;
            rd_cells(cv);
            chk($sformatf("step%0d_cells", k), cv, exp30[k]);
            cyc();
            chk($sformatf("step%0d_done_drop", k), step_done, 1'b0);
        end
        chk("step_done_count", nd, 3);
        chk("step_gen", gen_count, 16'd3);

        // Free-running: steps at edges 4, 8, 12; step_req overlapping the tick at 8
        do_reset();
        run = 1'b1;
        done_mask = '0;
        for (int k = 1; k <= 12; k++) begin
            step_req = (k == 8);
            cyc();
            done_mask[k-1] = step_done;
        end
        step_req = 1'b0;
        run = 1'b0;
        chk("run_done_mask", done_mask, 12'b1000_1000_1000);
        chk("run_gen", gen_count, 16'd3);
        rd_cells(cv);
        chk("run_cells", cv, 16'h000D);

        // Edge handling
        load(1'b0, 8'h00);
        load(1'b1, 8'h80);
        rd_cells(cv);
        chk("load_cells", cv, 16'h8000);
        wrap_en = 1'b1;
        step();
        rd_cells(cv);
        chk("wrap_cells", cv, 16'h8001);
        chk("wrap_still", still, 1'b0);
        wrap_en = 1'b0;
        load(1'b0, 8'h00);
        step();
        rd_cells(cv);
        chk("nowrap_cells", cv, 16'h8000);
        chk("nowrap_still", still, 1'b1);

        // Load wins over a concurrent step
        g0 = gen_count;
        load_addr = 1'b0;
        load_data = 8'hAA;
        load_we   = 1'b1;
        step_req  = 1'b1;
        cyc();
        load_we   = 1'b0;
        step_req  = 1'b0;
        rd_cells(cv);
        chk("ldstep_cells", cv, 16'h80AA);
        chk("ldstep_gen", gen_count, g0);
        chk("ldstep_done", step_done, 1'b0);
        chk("ldstep_still", still, 1'b0);

        // Rule write with concurrent step uses the old rule
        do_reset();
        rule_in  = 8'h00;
        rule_we  = 1'b1;
        step_req = 1'b1;
        cyc();
        rule_we  = 1'b0;
        step_req = 1'b0;
        rd_cells(cv);
        chk("rule_old_cells", cv, 16'h0003);
        step();
        rd_cells(cv);
        chk("rule0_cells", cv, 16'h0000);
        chk("rule0_alive", alive, 1'b0);
        chk("rule0_still_a", still, 1'b0);
        step();
        chk("rule0_still_b", still, 1'b1);

        // Dropping run mid-count restarts the interval
        do_reset();
        run = 1'b1;
        cyc();
        cyc();
        run = 1'b0;
        cyc();
        chk("runoff_gen", gen_count, 16'd0);
        run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            m4[k-1] = step_done;
        end
        run = 1'b0;
        chk("runoff_mask", m4, 4'b1000);

        // gen_count wrap
        do_reset();
        step_req = 1'b1;
        repeat (65535) cyc();
        step_req = 1'b0;
        chk("gen_ffff", gen_count, 16'hFFFF);
        step();
        chk("gen_wrap", gen_count, 16'h0000);

        // Reset with a tick pending overrides it; rule returns to default
        rule_in = 8'h00;
        rule_we = 1'b1;
        cyc();
        rule_we = 1'b0;
        run = 1'b1;
        cyc();
        cyc();
        cyc();
        reset    = 1'b1;
        step_req = 1'b1;
        cyc();
        reset    = 1'b0;
        step_req = 1'b0;
        chk("mrst_done", step_done, 1'b0);
        chk("mrst_gen", gen_count, 16'd0);
        chk("mrst_still", still, 1'b0);
        rd_cells(cv);
        chk("mrst_cells", cv, 16'h0001);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            m4[k-1] = step_done;
        end
        run = 1'b0;
        chk("mrst_mask", m4, 4'b1000);
        rd_cells(cv);
        chk("mrst_rule", cv, 16'h0003);
        chk("mrst_gen1", gen_count, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
